// File: rtl/verify_pkg.sv
// rtl/verify_pkg.sv - shared types, ASCII constants and character classifier for verify_param
package verify_pkg;

  typedef enum logic [2:0] {IDLE, LEAD, VOW, PUN, DIG, ERR} state_t;
  typedef enum logic [2:0] {C_NUL, C_SP, C_VOW, C_PUN, C_DIG, C_OTH} char_class_t;

  localparam logic [7:0] NUL     = 8'h00;
  localparam logic [7:0] SP      = 8'h20;
  localparam logic [7:0] P_COMMA = 8'h2C;
  localparam logic [7:0] P_BANG  = 8'h21;
  localparam logic [7:0] P_DOT   = 8'h2E;
  localparam logic [7:0] P_QUES  = 8'h3F;
  localparam logic [7:0] P_SEMI  = 8'h3B;
  localparam logic [7:0] P_COLON = 8'h3A;

  // case_mode: 0 = either case, 1 = lowercase only, 2 = uppercase only
  function automatic char_class_t classify(input logic [7:0] c, input logic [1:0] case_mode);
    logic lower_v;
    logic upper_v;
    lower_v = (c == 8'h61) || (c == 8'h65) || (c == 8'h69) || (c == 8'h6F) || (c == 8'h75);
    upper_v = (c == 8'h41) || (c == 8'h45) || (c == 8'h49) || (c == 8'h4F) || (c == 8'h55);
    if (c == NUL)
      return C_NUL;
    else if (c == SP)
      return C_SP;
    else if ((lower_v && case_mode != 2'd2) || (upper_v && case_mode != 2'd1))
      return C_VOW;
    else if ((c == P_COMMA) || (c == P_BANG) || (c == P_DOT) ||
             (c == P_QUES) || (c == P_SEMI) || (c == P_COLON))
      return C_PUN;
    else if ((c >= 8'h30) && (c <= 8'h39))
      return C_DIG;
    else
      return C_OTH;
  endfunction

endpackage

// File: rtl/verify_param_if.sv
// rtl/verify_param_if.sv - character input and verdict output bundle for verify_param
interface verify_param_if #(
  parameter int CNT_W = 8
);
  logic [7:0]       ascii_char;
  logic             char_valid;
  logic             sequence_valid;
  logic             output_strobe;
  logic [CNT_W-1:0] valid_count;
  logic [CNT_W-1:0] error_count;

  modport master (
    output ascii_char, char_valid,
    input  sequence_valid, output_strobe, valid_count, error_count
  );

  modport slave (
    input  ascii_char, char_valid,
    output sequence_valid, output_strobe, valid_count, error_count
  );
endinterface

// File: rtl/verify_strobe_timer.sv
// rtl/verify_strobe_timer.sv - retriggerable down-counter holding the verdict strobe high
module verify_strobe_timer #(
  parameter int STROBE_LEN = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic strobe
);
  localparam int TW = $clog2(STROBE_LEN + 1);

  logic [TW-1:0] timer;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      timer <= '0;
    else if (load)
      timer <= TW'(STROBE_LEN);
    else if (timer != '0)
      timer <= timer - 1'b1;
  end

  assign strobe = (timer != '0);

endmodule

// File: rtl/verify_param.sv
// rtl/verify_param.sv - NUL-delimited frame recogniser with verdict strobe and saturating counters
module verify_param #(
  parameter int UART_TX_baud = 20,
  parameter int freq         = 200,
  parameter int MAX_VOWELS   = 8,
  parameter int MAX_DIGITS   = 8,
  parameter int CASE_MODE    = 0,
  parameter int CNT_W        = 8
) (
  input  logic         clk,
  input  logic         rst,
  verify_param_if.slave bus
);
  import verify_pkg::*;

  localparam int STROBE_LEN = ((freq / UART_TX_baud) > 1) ? (freq / UART_TX_baud) : 1;
  localparam int VW = $clog2(MAX_VOWELS + 1);
  localparam int DW = $clog2(MAX_DIGITS + 1);

  state_t           state, state_nx;
  logic [VW-1:0]    vcnt, vcnt_nx;
  logic [DW-1:0]    dcnt, dcnt_nx;
  logic             lead_seen, lead_seen_nx;
  logic             verdict, verdict_pass;
  logic             seq_q;
  logic [CNT_W-1:0] vcount_q, ecount_q;
  logic             strobe;
  char_class_t      cls;

  assign cls = classify(bus.ascii_char, 2'(CASE_MODE));

  always_comb begin
    state_nx     = state;
    vcnt_nx      = vcnt;
    dcnt_nx      = dcnt;
    lead_seen_nx = lead_seen;
    verdict      = 1'b0;
    verdict_pass = 1'b0;
    if (bus.char_valid) begin
      case (state)
        IDLE: if (cls == C_NUL) state_nx = LEAD;
        LEAD: begin
          case (cls)
            C_SP:  lead_seen_nx = 1'b1;
            C_VOW: begin state_nx = VOW; vcnt_nx = VW'(1); end
            // spaces-only frames are failures; a bare NUL,NUL is not a frame at all
            C_NUL: begin verdict = lead_seen; lead_seen_nx = 1'b0; end
            default: state_nx = ERR;
          endcase
        end
        VOW: begin
          case (cls)
            C_VOW: begin
              if (vcnt == VW'(MAX_VOWELS)) state_nx = ERR;
              else                         vcnt_nx  = vcnt + 1'b1;
            end
            C_PUN:   state_nx = PUN;
            C_NUL:   begin verdict = 1'b1; state_nx = LEAD; end
            default: state_nx = ERR;
          endcase
        end
        PUN: begin
          case (cls)
            C_DIG:   begin state_nx = DIG; dcnt_nx = DW'(1); end
            C_NUL:   begin verdict = 1'b1; state_nx = LEAD; end
            default: state_nx = ERR;
          endcase
        end
        DIG: begin
          case (cls)
            C_DIG: begin
              if (dcnt == DW'(MAX_DIGITS)) state_nx = ERR;
              else                         dcnt_nx  = dcnt + 1'b1;
            end
            C_NUL:   begin verdict = 1'b1; verdict_pass = 1'b1; state_nx = LEAD; end
            default: state_nx = ERR;
          endcase
        end
        ERR: if (cls == C_NUL) begin verdict = 1'b1; state_nx = LEAD; end
        default: state_nx = IDLE;
      endcase
    end
    if (state_nx != LEAD) lead_seen_nx = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      vcnt      <= '0;
      dcnt      <= '0;
      lead_seen <= 1'b0;
      seq_q     <= 1'b0;
      vcount_q  <= '0;
      ecount_q  <= '0;
    end else begin
      state     <= state_nx;
      vcnt      <= vcnt_nx;
      dcnt      <= dcnt_nx;
      lead_seen <= lead_seen_nx;
      if (verdict) begin
        seq_q <= verdict_pass;
        if (verdict_pass) begin
          if (vcount_q != '1) vcount_q <= vcount_q + 1'b1;
        end else begin
          if (ecount_q != '1) ecount_q <= ecount_q + 1'b1;
        end
      end
    end
  end

  verify_strobe_timer #(
    .STROBE_LEN(STROBE_LEN)
  ) u_strobe_timer (
    .clk   (clk),
    .rst   (rst),
    .load  (verdict),
    .strobe(strobe)
  );

  assign bus.sequence_valid = seq_q;
  assign bus.output_strobe  = strobe;
  assign bus.valid_count    = vcount_q;
  assign bus.error_count    = ecount_q;

endmodule

// File: doc/verify_param.md
Name: verify_param

Overview:
Parametrised successor to the single-grammar `verify` recogniser. It consumes a NUL-delimited ASCII character stream (one char per `char_valid` strobe, typically from the UART RX path). At the end of each frame it issues a pass/fail verdict, and the verdict is presented on a held level plus a strobe that lasts one UART TX bit time. Added over the previous generation:
- configurable vowel/digit length limits
- case mode
- explicit empty-frame handling
- saturating pass/fail counters

Parameters:
UART_TX_baud, 20, TX baud rate; sets the strobe length.
freq, 200, system clock rate in the same units as UART_TX_baud.
MAX_VOWELS, 8, maximum vowels per frame (must be ≥1).
MAX_DIGITS, 8, maximum digits per frame (must be ≥1).
CASE_MODE, 0, vowel case rule: 0 = any case (mixing allowed), 1 = lowercase only, 2 = uppercase only.
CNT_W, 8, width of the verdict counters.
STROBE_LEN (localparam), max(1, freq/UART_TX_baud), strobe length in clocks.

Ports:
clk  in  1  system clock; all state updates on the rising edge.
rst  in  1  reset, asynchronous, active-high.
ascii_char  in  8  incoming character.
char_valid  in  1  one-cycle qualifier; the char is consumed on the edge where this is 1.
sequence_valid  out  1  last verdict: 1 = pass, 0 = fail; held until the next verdict.
output_strobe  out  1  high for STROBE_LEN cycles after each verdict.
valid_count  out  CNT_W  number of passing frames, saturating.
error_count  out  CNT_W  number of failing frames, saturating.

Behaviour:
- Reset (async assert, sync release): state=IDLE; every output is 0; both internal length counters and the strobe timer are 0.
- Frame grammar, between NULs: SP* V{1..MAX_VOWELS} P D{1..MAX_DIGITS}
  - V = a e i o u, restricted by CASE_MODE; y is not a vowel.
  - P = one of , ! . ? ; :
  - D = 0-9
- States and transitions (evaluated only when char_valid=1):
  - IDLE: NUL -> LEAD; any other char is ignored until a NUL arrives (resync).
  - LEAD: SP -> LEAD; V -> VOW (vcnt=1); NUL -> LEAD with no verdict (empty frame); anything else -> ERR.
  - VOW:
    - V with vcnt<MAX_VOWELS -> VOW, vcnt+1.
    - V with vcnt=MAX_VOWELS -> ERR.
    - P -> PUN.
    - NUL -> verdict fail, then LEAD.
    - anything else -> ERR.
  - PUN: D -> DIG (dcnt=1); NUL -> verdict fail, then LEAD; anything else -> ERR.
  - DIG:
    - D with dcnt<MAX_DIGITS -> DIG, dcnt+1.
    - D with dcnt=MAX_DIGITS -> ERR.
    - NUL -> verdict pass, then LEAD.
    - anything else -> ERR.
  - ERR: non-NUL -> ERR; NUL -> verdict fail, then LEAD.
- A frame containing only spaces is a fail frame, not an empty frame: LEAD must record that a non-NUL char was seen. Only NUL,NUL with nothing in between yields no verdict.
- Verdict, latency 1: on the edge that consumes the terminating NUL:
  - sequence_valid is loaded with the result.
  - output_strobe goes high and stays high for exactly STROBE_LEN cycles.
  - the corresponding counter increments; at all-ones it holds (saturates).
- New verdict while the strobe is active: the timer restarts at STROBE_LEN, sequence_valid updates, and the strobe stays high continuously.
- char_valid=0: no state change; the strobe timer still runs.
- Reset asserted mid-frame or mid-strobe: everything returns to reset values immediately. The partial frame is discarded and the next frame needs a leading NUL.
- Case check when CASE_MODE=1/2: a vowel of the wrong case counts as "anything else" (goes to ERR).
- Counter widths: vcnt sized $clog2(MAX_VOWELS+1); dcnt sized $clog2(MAX_DIGITS+1).

Decomposition:
- Package verify_pkg holds:
  - the state enum (IDLE, LEAD, VOW, PUN, DIG, ERR)
  - ASCII constants (NUL, SP, punctuation set)
  - char-class enum (C_NUL, C_SP, C_VOW, C_PUN, C_DIG, C_OTH)
  - function classify(char, case_mode)
- One sub-module, verify_strobe_timer: loads on verdict, counts down STROBE_LEN, drives output_strobe.

Test Plan:
1. Defaults; stream 0," aei!12",0 -> one cycle after the final NUL: sequence_valid=1, output_strobe high 10 cycles, valid_count=1.
2. Stream 0,"OU,5",0, then 0,"aeiX12",0 -> verdicts pass then fail. Final state: sequence_valid=0, valid_count=1, error_count=1. The 0,0 boundary between the two frames produces no strobe.
3. MAX_DIGITS=2; frame "a.123" -> fail. MAX_VOWELS=3; frame "aeio!1" -> fail. Frame "aei!12" -> pass.
4. CASE_MODE=1; frames "aE!1" -> fail, "ae!1" -> pass. CASE_MODE=2; frames "AE!1" -> pass, "ae!1" -> fail.
5. Two short frames with char_valid every cycle, so verdicts come 3 cycles apart -> output_strobe is continuous for 3+10 cycles and sequence_valid follows each verdict.
6. CNT_W=2; 5 passing frames -> valid_count saturates at 3. Assert rst mid-frame after "ae" -> all outputs 0 at once; a following 0,"i!7",0 -> pass.
